// File: rtl/angle_sync_ctrl_pkg.sv
// Shared types and defaults for the grid-sync angle controller:
// FSM state encoding, frequency/sequence codes and nominal 25 MHz thresholds.
package angle_sync_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_MEAS   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic F50     = 1'b1;
  localparam logic F60     = 1'b0;
  localparam logic SEQ_ABC = 1'b1;
  localparam logic SEQ_ACB = 1'b0;

  localparam int DEF_CNT_W     = 20;
  localparam int DEF_DEB_CYC   = 16;
  localparam int DEF_PER_MIN   = 380_000;
  localparam int DEF_PER_MAX   = 550_000;
  localparam int DEF_PER_SPLIT = 458_333;
  localparam int DEF_LOCK_N    = 2;
  localparam logic [9:0] DEF_ZC_THETA = 10'd0;

  localparam int AGR_W = 4;

  // First kick word: a one-LSB offset so the generator sees a theta change.
  function automatic logic [9:0] theta_inc(input logic [9:0] t);
    return t + 10'd1;
  endfunction

endpackage

// File: rtl/angle_sync_ctrl_zc_filter.sv
// Zero-cross input conditioning: 2-FF synchroniser followed by a debounce
// that only accepts a new level after DEB_CYC consecutive differing samples.
module angle_sync_ctrl_zc_filter #(
  parameter int DEB_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_zc,
  output logic o_filt
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [DW-1:0] r_deb;

  // Synchroniser and debounce counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_deb   <= {DW{1'b0}};
    end else begin
      r_sync1 <= i_zc;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_deb <= {DW{1'b0}};
      end else if (r_deb == DEB_LAST) begin
        r_filt <= r_sync2;
        r_deb  <= {DW{1'b0}};
      end else begin
        r_deb <= r_deb + DW'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/angle_sync_ctrl.sv
// Grid-sync controller: measures the phase-A period, classifies 50/60 Hz,
// detects phase sequence and kicks the angle generator on each rising zero-cross.
module angle_sync_ctrl
  import angle_sync_ctrl_pkg::*;
#(
  parameter int         CNT_W     = DEF_CNT_W,
  parameter int         DEB_CYC   = DEF_DEB_CYC,
  parameter int         PER_MIN   = DEF_PER_MIN,
  parameter int         PER_MAX   = DEF_PER_MAX,
  parameter int         PER_SPLIT = DEF_PER_SPLIT,
  parameter int         LOCK_N    = DEF_LOCK_N,
  parameter logic [9:0] ZC_THETA  = DEF_ZC_THETA
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_clr_fault,
  input  logic             i_zc_a,
  input  logic             i_zc_b,
  output logic [9:0]       o_theta_cmd,
  output logic             o_freq,
  output logic             o_sequence,
  output logic             o_locked,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_period
);

  localparam logic [CNT_W-1:0] L_PER_MIN   = CNT_W'(PER_MIN);
  localparam logic [CNT_W-1:0] L_PER_MAX   = CNT_W'(PER_MAX);
  localparam logic [CNT_W-1:0] L_PER_SPLIT = CNT_W'(PER_SPLIT);
  localparam logic [AGR_W-1:0] L_LOCK_N    = AGR_W'(LOCK_N);

  logic             w_a_filt;
  logic             w_b_filt;
  logic             r_a_filt_d;
  logic             w_rise_a;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_p1;
  logic             w_valid;
  logic             w_cls;
  logic             w_seq;
  logic             w_timeout;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AGR_W-1:0] r_agree;
  logic [AGR_W-1:0] w_agree_nxt;
  logic             r_prev_cls;
  logic             w_prev_cls_nxt;
  logic             r_freq;
  logic             w_freq_nxt;
  logic             r_seq;
  logic             w_seq_nxt;
  logic             w_kick;
  logic             r_kick2;
  logic             r_locked;
  logic             r_fault;
  logic [9:0]       r_theta;
  logic [CNT_W-1:0] r_period;

  angle_sync_ctrl_zc_filter #(.DEB_CYC(DEB_CYC)) u_filt_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_zc    (i_zc_a),
    .o_filt  (w_a_filt)
  );

  angle_sync_ctrl_zc_filter #(.DEB_CYC(DEB_CYC)) u_filt_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_zc    (i_zc_b),
    .o_filt  (w_b_filt)
  );

  assign w_rise_a  = w_a_filt & ~r_a_filt_d;
  assign w_cnt_p1  = r_cnt + CNT_W'(1);
  assign w_valid   = (w_cnt_p1 >= L_PER_MIN) && (w_cnt_p1 <= L_PER_MAX);
  assign w_cls     = (w_cnt_p1 < L_PER_SPLIT) ? F60 : F50;
  // B still negative at the A rising edge means B lags A: ABC rotation.
  assign w_seq     = w_b_filt ? SEQ_ACB : SEQ_ABC;
  assign w_timeout = (r_cnt == L_PER_MAX);

  // Period counter, edge history and last measured period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_filt_d <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
      r_period   <= {CNT_W{1'b0}};
    end else begin
      r_a_filt_d <= w_a_filt;
      if (w_rise_a) begin
        r_cnt    <= {CNT_W{1'b0}};
        r_period <= w_cnt_p1;
      end else if (!w_timeout) begin
        r_cnt <= w_cnt_p1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Next-state logic; enable=0 overrides everything, timeout beats rise_a.
  always_comb begin
    w_state_nxt    = r_state;
    w_agree_nxt    = r_agree;
    w_prev_cls_nxt = r_prev_cls;
    w_freq_nxt     = r_freq;
    w_seq_nxt      = r_seq;
    w_kick         = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (w_rise_a) begin
            w_state_nxt = ST_MEAS;
            w_agree_nxt = {AGR_W{1'b0}};
          end else begin
            w_state_nxt = ST_ACQ;
          end
        end
        ST_MEAS: begin
          if (w_timeout) begin
            w_state_nxt = ST_FAULT;
          end else if (w_rise_a) begin
            if (!w_valid) begin
              w_state_nxt = ST_FAULT;
            end else begin
              if ((r_agree == {AGR_W{1'b0}}) || (w_cls == r_prev_cls)) begin
                w_agree_nxt = r_agree + AGR_W'(1);
              end else begin
                w_agree_nxt = AGR_W'(1);
              end
              w_prev_cls_nxt = w_cls;
              if (w_agree_nxt >= L_LOCK_N) begin
                w_state_nxt = ST_LOCKED;
                w_freq_nxt  = w_cls;
                w_seq_nxt   = w_seq;
                w_kick      = 1'b1;
              end else begin
                w_state_nxt = ST_MEAS;
              end
            end
          end else begin
            w_state_nxt = ST_MEAS;
          end
        end
        ST_LOCKED: begin
          if (w_timeout) begin
            w_state_nxt = ST_FAULT;
          end else if (w_rise_a) begin
            if (w_valid) begin
              w_freq_nxt = w_cls;
              w_seq_nxt  = w_seq;
              w_kick     = 1'b1;
            end else begin
              w_state_nxt = ST_FAULT;
            end
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_FAULT: begin
          if (i_clr_fault) begin
            w_state_nxt = ST_ACQ;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_agree    <= {AGR_W{1'b0}};
      r_prev_cls <= F50;
      r_freq     <= F50;
      r_seq      <= SEQ_ABC;
      r_locked   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_agree    <= w_agree_nxt;
      r_prev_cls <= w_prev_cls_nxt;
      r_freq     <= w_freq_nxt;
      r_seq      <= w_seq_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_fault    <= (w_state_nxt == ST_FAULT);
    end
  end

  // Kick sequencer: ZC_THETA+1 then ZC_THETA so the generator always reloads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_theta <= 10'd0;
      r_kick2 <= 1'b0;
    end else if (w_kick) begin
      r_theta <= theta_inc(ZC_THETA);
      r_kick2 <= 1'b1;
    end else if (r_kick2) begin
      r_theta <= ZC_THETA;
      r_kick2 <= 1'b0;
    end else begin
      r_theta <= r_theta;
      r_kick2 <= 1'b0;
    end
  end

  assign o_theta_cmd = r_theta;
  assign o_freq      = r_freq;
  assign o_sequence  = r_seq;
  assign o_locked    = r_locked;
  assign o_fault     = r_fault;
  assign o_period    = r_period;

endmodule

// File: tb/tb_angle_sync_ctrl.sv
// Scoreboard bench for angle_sync_ctrl with periods scaled down 1000x.
// Stimulus queues expected output events; a negedge monitor pops one per output change.
module tb_angle_sync_ctrl;

  localparam int CNT_W  = 12;
  localparam int DEB    = 16;
  localparam int PMIN   = 380;
  localparam int PMAX   = 550;
  localparam int PSPLIT = 458;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             clr_fault;
  logic             zc_a;
  logic             zc_b;
  logic [9:0]       theta_cmd;
  logic             freq;
  logic             sequence_o;
  logic             locked;
  logic             fault;
  logic [CNT_W-1:0] period;

  angle_sync_ctrl #(
    .CNT_W(CNT_W), .DEB_CYC(DEB), .PER_MIN(PMIN), .PER_MAX(PMAX),
    .PER_SPLIT(PSPLIT), .LOCK_N(2), .ZC_THETA(10'd0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clr_fault(clr_fault),
    .i_zc_a(zc_a), .i_zc_b(zc_b), .o_theta_cmd(theta_cmd), .o_freq(freq),
    .o_sequence(sequence_o), .o_locked(locked), .o_fault(fault), .o_period(period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // v = {theta, freq, sequence, locked, fault}; -1 in per/dt/at means not checked
  typedef struct {
    logic [13:0] v;
    int          per;
    int          dt;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;
  bit   final_done = 1'b0;
  bit   wait_to = 1'b0;

  function automatic void push(logic [9:0] th, logic fq, logic sq, logic lk, logic ft,
                               int per, int dt, int at);
    exp_t e;
    e.v   = {th, fq, sq, lk, ft};
    e.per = per;
    e.dt  = dt;
    e.at  = at;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  logic [13:0] mon_cur;
  logic [13:0] mon_prev = 14'd0;
  bit          mon_first = 1'b1;
  int          last_ev = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    mon_cur = {theta_cmd, freq, sequence_o, locked, fault};
    if (mon_first || (mon_cur != mon_prev)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'(mon_cur), -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("outputs", int'(mon_cur), int'(mon_e.v));
        if (mon_e.per >= 0) chk("period", int'(period), mon_e.per);
        if (mon_e.dt >= 0)  chk("event_gap", cyc - last_ev, mon_e.dt);
        if (mon_e.at >= 0)  chk("event_cycle", cyc, mon_e.at);
      end
      last_ev = cyc;
    end
    mon_prev  = mon_cur;
    mon_first = 1'b0;
    if (done && !final_done) begin
      chk("pending_events", exp_q.size(), 0);
      chk("kick_wait", int'(wait_to), 0);
      final_done = 1'b1;
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One grid period: A rises at ph=0; B is A shifted by 120 deg (lag for ABC, lead for ACB).
  task automatic one_period(int p, bit abc, bit glitch);
    int off;
    int bpos;
    off = abc ? p / 3 : (2 * p) / 3;
    for (int ph = 0; ph < p; ph++) begin
      bpos = (ph + p - off) % p;
      zc_a = (ph < p / 2) || (glitch && ph >= 300 && ph < 300 + DEB - 1);
      zc_b = (bpos < p / 2);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_kick(logic fq, logic sq, int per, int dt);
    push(10'd1, fq, sq, 1'b1, 1'b0, per, dt, -1);
    push(10'd0, fq, sq, 1'b1, 1'b0, -1, 1, -1);
  endtask

  initial begin
    bit found;
    rst_n = 1'b1; enable = 1'b0; clr_fault = 1'b0; zc_a = 1'b0; zc_b = 1'b0;
    #2 rst_n = 1'b0;
    push(10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, -1);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    enable = 1'b1;
    idle(20);

    // 50 Hz ABC: lock on 3rd rise, steady kicks, then a sub-threshold glitch
    push_kick(1'b1, 1'b1, 500, -1);
    push_kick(1'b1, 1'b1, 500, 499);
    push_kick(1'b1, 1'b1, 500, 499);
    push_kick(1'b1, 1'b1, 500, 499);
    repeat (4) one_period(500, 1'b1, 1'b0);
    one_period(500, 1'b1, 1'b1);
    one_period(500, 1'b1, 1'b0);

    // A static: timeout exactly PER_MAX cycles after the last kick word, then clear
    push(10'd0, 1'b1, 1'b1, 1'b0, 1'b1, -1, PMAX, -1);
    zc_a = 1'b0; zc_b = 1'b0;
    idle(300);
    clr_fault = 1'b1;
    push(10'd0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, cyc + 1);
    idle(1);
    clr_fault = 1'b0;
    idle(5);

    // 60 Hz ACB relock, then enable drop while locked
    push_kick(1'b0, 1'b0, 417, -1);
    push_kick(1'b0, 1'b0, 417, 416);
    repeat (3) one_period(417, 1'b0, 1'b0);
    fork
      one_period(417, 1'b0, 1'b0);
      begin
        idle(100);
        enable = 1'b0;
        push(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, cyc + 1);
        idle(1);
        enable = 1'b1;
      end
    join

    // Alternating classes never lock; two equal 50 Hz periods then lock
    one_period(500, 1'b0, 1'b0);
    one_period(417, 1'b0, 1'b0);
    one_period(500, 1'b0, 1'b0);
    one_period(417, 1'b0, 1'b0);
    one_period(500, 1'b0, 1'b0);
    push_kick(1'b1, 1'b1, 500, -1);
    push(10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 500, 499, -1);
    one_period(500, 1'b1, 1'b0);
    one_period(500, 1'b1, 1'b0);

    // Reset between the two kick words
    fork
      one_period(500, 1'b1, 1'b0);
      begin
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
          @(negedge clk);
          if (theta_cmd == 10'd1) found = 1'b1;
        end
        if (found) begin
          #2 rst_n = 1'b0;
          push(10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, cyc + 1);
          repeat (3) @(posedge clk);
          #1 rst_n = 1'b1;
        end else begin
          wait_to = 1'b1;
        end
      end
    join
    idle(20);
    done = 1'b1;
    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
